// File: rtl/instr_dispatch_pkg.sv
// Shared definitions for the instruction dispatcher: default geometry,
// fault code encodings, dispatcher state encoding and a small helper.
package instr_dispatch_pkg;

  // Default geometry. The opcode is the top OP_W bits of the instruction word,
  // and the all-ones opcode is reserved for HALT.
  localparam int DEF_IR_W    = 16;
  localparam int DEF_OP_W    = 4;
  localparam int DEF_N_FSM   = 8;
  localparam int DEF_TIMEOUT = 15;
  localparam int DEF_RECOVER = 2;

  // Sticky fault cause reported on fault_code.
  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_ILLEGAL    = 2'b01,
    FC_TIMEOUT    = 2'b10,
    FC_WRONG_DONE = 2'b11
  } fault_code_e;

  // Dispatcher state, also exported on state_dbg.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_LATCH  = 4'd2,
    S_DECODE = 4'd3,
    S_ISSUE  = 4'd4,
    S_WAIT   = 4'd5,
    S_RECOV  = 4'd6,
    S_FAULT  = 4'd7,
    S_HALT   = 4'd8
  } dispatch_state_e;

  // Larger of two integers; used to size the shared timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/instr_dispatch_timer.sv
// Saturating up-counter with synchronous clear and compare-to-limit.
// The dispatcher shares one instance between the Done timeout (WAIT) and
// the recovery gap (RECOV); the two uses never overlap in time.
module instr_dispatch_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] cnt;

  // Count enabled cycles, stop at the limit, restart from zero on clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == limit);

endmodule

// File: rtl/instr_dispatch.sv
// Instruction dispatcher: fetches an instruction word, decodes the opcode and
// starts exactly one execution FSM, then waits for its Done, leaves a short
// recovery gap and fetches again. PC stepping belongs to the execution FSMs.
//
// start/done handshake: start[op] is a single-cycle pulse; the addressed FSM
// answers with a single-cycle done[op] pulse some cycles later. Exactly one
// Done, from the started FSM, is legal per start; any other Done bit, several
// bits at once, or a Done while nothing is outstanding is a protocol fault.
// A Done arriving in the very cycle the timeout limit is reached still counts.
module instr_dispatch
  import instr_dispatch_pkg::*;
#(
  parameter int IR_W    = DEF_IR_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int N_FSM   = DEF_N_FSM,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int RECOVER = DEF_RECOVER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             fault_clr,
  output logic             imem_rd,
  input  logic [IR_W-1:0]  imem_data,
  output logic [IR_W-1:0]  ir,
  output logic [N_FSM-1:0] start,
  input  logic [N_FSM-1:0] done,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic             halted,
  output logic [3:0]       state_dbg
);

  // RECOV lasts RECOVER cycles, so the timer leaves it at count RECOVER-1.
  // A zero gap is not meaningful for the responders; treat it as one cycle.
  localparam int REC_LIM = (RECOVER < 1) ? 0 : RECOVER - 1;
  localparam int TW      = $clog2(max_int(TIMEOUT, REC_LIM) + 1);

  dispatch_state_e  state;
  fault_code_e      new_code;
  logic             enter_fault;
  logic [OP_W-1:0]  op_sel;
  logic             op_halt;
  logic             op_illegal;
  logic [N_FSM-1:0] exp_done;
  logic             done_any;
  logic             done_ok;
  logic             tmr_clr;
  logic             tmr_en;
  logic [TW-1:0]    tmr_limit;
  logic             tmr_hit;

  // Opcode decode from the latched instruction register.
  assign op_sel     = ir[IR_W-1 -: OP_W];
  assign op_halt    = &op_sel;
  assign op_illegal = !op_halt && (int'(op_sel) >= N_FSM);
  assign exp_done   = N_FSM'(1) << op_sel;
  assign done_any   = |done;
  assign done_ok    = done_any && (done == exp_done);

  // The timer runs only in WAIT and RECOV and is cleared whenever either is
  // about to be entered, so each use starts from zero.
  assign tmr_en    = (state == S_WAIT) || (state == S_RECOV);
  assign tmr_clr   = !tmr_en || ((state == S_WAIT) && done_any);
  assign tmr_limit = (state == S_RECOV) ? TW'(REC_LIM) : TW'(TIMEOUT);

  instr_dispatch_timer #(
    .W (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .hit   (tmr_hit)
  );

  // Fault detection: decides whether this cycle moves the FSM into FAULT and
  // with which cause. FAULT and HALT ignore everything but fault_clr.
  always_comb begin
    enter_fault = 1'b0;
    new_code    = FC_NONE;
    case (state)
      S_IDLE, S_FETCH, S_LATCH, S_RECOV: begin
        if (done_any) begin
          enter_fault = 1'b1;
          new_code    = FC_WRONG_DONE;
        end
      end
      S_DECODE: begin
        if (done_any) begin
          enter_fault = 1'b1;
          new_code    = FC_WRONG_DONE;
        end else if (op_illegal) begin
          enter_fault = 1'b1;
          new_code    = FC_ILLEGAL;
        end
      end
      S_ISSUE: begin
        if (done_any && !done_ok) begin
          enter_fault = 1'b1;
          new_code    = FC_WRONG_DONE;
        end
      end
      S_WAIT: begin
        if (done_any && !done_ok) begin
          enter_fault = 1'b1;
          new_code    = FC_WRONG_DONE;
        end else if (!done_any && tmr_hit) begin
          enter_fault = 1'b1;
          new_code    = FC_TIMEOUT;
        end
      end
      default: begin
      end
    endcase
  end

  // Dispatcher FSM with registered Moore outputs; each output is set on the
  // transition into the state that owns it, so nothing from done reaches
  // start combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ir         <= '0;
      start      <= '0;
      imem_rd    <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      halted     <= 1'b0;
    end else begin
      start   <= '0;
      imem_rd <= 1'b0;
      if (enter_fault) begin
        state      <= S_FAULT;
        fault      <= 1'b1;
        fault_code <= new_code;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (run) begin
              state   <= S_FETCH;
              imem_rd <= 1'b1;
              busy    <= 1'b1;
            end
          end
          S_FETCH: begin
            state <= S_LATCH;
          end
          S_LATCH: begin
            ir    <= imem_data;
            state <= S_DECODE;
          end
          S_DECODE: begin
            if (op_halt) begin
              state  <= S_HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
            end else begin
              state <= S_ISSUE;
              start <= exp_done;
            end
          end
          S_ISSUE: begin
            state <= done_ok ? S_RECOV : S_WAIT;
          end
          S_WAIT: begin
            if (done_ok) begin
              state <= S_RECOV;
            end
          end
          S_RECOV: begin
            if (tmr_hit) begin
              if (run) begin
                state   <= S_FETCH;
                imem_rd <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          S_FAULT, S_HALT: begin
            if (fault_clr) begin
              state      <= S_IDLE;
              fault      <= 1'b0;
              fault_code <= FC_NONE;
              halted     <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_instr_dispatch.sv
// Bench for instr_dispatch: instruction memory and responder models run
// cycle by cycle inside tick(); expected event cycles come from the
// dispatcher's documented latencies computed with plain arithmetic.
module tb_instr_dispatch;

  localparam int TIMEOUT = 15;
  localparam int RECOVER = 2;

  logic        clk;
  logic        reset;
  logic        run;
  logic        fault_clr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic [15:0] ir;
  logic [7:0]  start;
  logic [7:0]  done;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_code;
  logic        halted;
  logic [3:0]  state_dbg;

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  // memory / responder model state
  logic [15:0] prog_q[$];
  int          dly_q[$];
  logic        mem_pend;
  logic [15:0] mem_word;
  int          resp_delay;
  logic [7:0]  resp_mask;
  logic [7:0]  rb_mask;
  logic [7:0]  inj_done;
  int          cd;

  // monitor logs
  int          rd_cyc[$];
  int          st_cyc[$];
  logic [7:0]  st_val[$];
  logic [15:0] st_ir[$];
  int          bz_cyc[$];
  int          dn_cyc[$];
  int          flt_cyc;
  bit          fault_seen;

  // scoreboard expectations
  int          exp_rd_q[$];
  int          exp_st_q[$];
  logic [7:0]  exp_val_q[$];
  logic [15:0] exp_ir_q[$];

  instr_dispatch #(
    .IR_W(16), .OP_W(4), .N_FSM(8), .TIMEOUT(TIMEOUT), .RECOVER(RECOVER)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .fault_clr(fault_clr),
    .imem_rd(imem_rd), .imem_data(imem_data), .ir(ir), .start(start),
    .done(done), .busy(busy), .fault(fault), .fault_code(fault_code),
    .halted(halted), .state_dbg(state_dbg)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle: observe outputs at the falling edge, then drive inputs.
  task automatic tick();
    int d;
    @(negedge clk);
    cyc++;
    if (imem_rd === 1'b1) rd_cyc.push_back(cyc);
    if (start !== 8'h00) begin
      st_cyc.push_back(cyc);
      st_val.push_back(start);
      st_ir.push_back(ir);
    end
    if (busy !== 1'b1) bz_cyc.push_back(cyc);
    if (fault === 1'b1 && !fault_seen) begin
      fault_seen = 1'b1;
      flt_cyc = cyc;
    end
    // memory: word appears only in the cycle after the read strobe
    if (mem_pend) begin
      imem_data = mem_word;
      mem_pend = 1'b0;
    end else begin
      imem_data = 16'($urandom);
    end
    if (imem_rd === 1'b1) begin
      mem_pend = 1'b1;
      if (prog_q.size() > 0) mem_word = prog_q.pop_front();
      else mem_word = 16'hF000 | 16'($urandom_range(0, 4095));
    end
    // responder: Done d cycles after the start cycle, d == 0 means never
    done = inj_done;
    inj_done = 8'h00;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        done = done | rb_mask;
        dn_cyc.push_back(cyc);
      end
    end
    if (start !== 8'h00) begin
      if (dly_q.size() > 0) d = dly_q.pop_front();
      else d = resp_delay;
      cd = d;
      rb_mask = (resp_mask != 8'h00) ? resp_mask : start;
    end
  endtask

  task automatic clear_logs();
    rd_cyc.delete(); st_cyc.delete(); st_val.delete(); st_ir.delete();
    bz_cyc.delete(); dn_cyc.delete(); prog_q.delete(); dly_q.delete();
    exp_rd_q.delete(); exp_st_q.delete(); exp_val_q.delete(); exp_ir_q.delete();
    fault_seen = 1'b0;
    flt_cyc = -1;
    cd = 0;
    resp_mask = 8'h00;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    vec++; if (start !== 8'h00) begin errs++; $display("FAIL reset_start got=%h exp=00", start); end
    vec++; if (imem_rd !== 1'b0) begin errs++; $display("FAIL reset_imem_rd got=%b exp=0", imem_rd); end
    vec++; if (ir !== 16'h0000) begin errs++; $display("FAIL reset_ir got=%h exp=0000", ir); end
    vec++; if ({busy, fault, halted} !== 3'b000) begin errs++; $display("FAIL reset_flags got=%b exp=000", {busy, fault, halted}); end
    vec++; if (fault_code !== 2'b00) begin errs++; $display("FAIL reset_fault_code got=%b exp=00", fault_code); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_movi();
    logic [15:0] w;
    int c0, nbz;
    clear_logs();
    w = {4'h0, 12'($urandom)};
    prog_q.push_back(w);
    prog_q.push_back(16'hF000);
    resp_delay = 5;
    c0 = cyc;
    run = 1'b1;
    repeat (18) tick();
    run = 1'b0;
    vec++;
    if (rd_cyc.size() != 2) begin errs++; $display("FAIL movi_rd_count got=%0d exp=2", rd_cyc.size()); end
    else begin
      vec++; if (rd_cyc[0] != c0 + 1) begin errs++; $display("FAIL movi_first_rd got=%0d exp=%0d", rd_cyc[0] - c0, 1); end
      vec++; if (rd_cyc[1] != c0 + 12) begin errs++; $display("FAIL movi_next_rd got=%0d exp=%0d", rd_cyc[1] - c0, 12); end
    end
    vec++;
    if (st_cyc.size() != 1) begin errs++; $display("FAIL movi_start_cycles got=%0d exp=1", st_cyc.size()); end
    else begin
      vec++; if (st_cyc[0] != c0 + 4) begin errs++; $display("FAIL movi_start_latency got=%0d exp=4", st_cyc[0] - c0); end
      vec++; if (st_val[0] !== 8'h01) begin errs++; $display("FAIL movi_start_val got=%h exp=01", st_val[0]); end
      vec++; if (st_ir[0] !== w) begin errs++; $display("FAIL movi_ir got=%h exp=%h", st_ir[0], w); end
    end
    nbz = 0;
    foreach (bz_cyc[i]) if (bz_cyc[i] >= c0 + 1 && bz_cyc[i] <= c0 + 12) nbz++;
    vec++; if (nbz != 0) begin errs++; $display("FAIL movi_busy_gaps got=%0d exp=0", nbz); end
    vec++; if (halted !== 1'b1) begin errs++; $display("FAIL movi_halt_after got=%b exp=1", halted); end
    pulse_clr();
  endtask

  task automatic test_illegal();
    int c0;
    clear_logs();
    prog_q.push_back({4'h9, 12'($urandom)});
    resp_delay = 5;
    c0 = cyc;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (10) tick();
    vec++; if (st_cyc.size() != 0) begin errs++; $display("FAIL illegal_start got=%0d exp=0", st_cyc.size()); end
    vec++; if (flt_cyc != c0 + 4) begin errs++; $display("FAIL illegal_fault_cycle got=%0d exp=4", flt_cyc - c0); end
    vec++; if (fault_code !== 2'b01) begin errs++; $display("FAIL illegal_code got=%b exp=01", fault_code); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL illegal_busy got=%b exp=0", busy); end
    // a later Done must not overwrite the first fault
    inj_done = 8'h10;
    repeat (2) tick();
    vec++; if (fault_code !== 2'b01) begin errs++; $display("FAIL first_fault_wins got=%b exp=01", fault_code); end
    pulse_clr();
    vec++; if ({fault, fault_code} !== 3'b000) begin errs++; $display("FAIL illegal_clear got=%b exp=000", {fault, fault_code}); end
    vec++; if (rd_cyc.size() != 1) begin errs++; $display("FAIL illegal_rd_count got=%0d exp=1", rd_cyc.size()); end
  endtask

  task automatic test_timeout();
    int c0;
    clear_logs();
    prog_q.push_back({4'h2, 12'($urandom)});
    resp_delay = 0;
    c0 = cyc;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (24) tick();
    vec++; if (st_cyc.size() != 1 || st_val[0] !== 8'h04) begin errs++; $display("FAIL timeout_start got_n=%0d exp=1 of 04", st_cyc.size()); end
    vec++; if (flt_cyc != c0 + 4 + TIMEOUT + 2) begin errs++; $display("FAIL timeout_cycle got=%0d exp=%0d", flt_cyc - c0, 4 + TIMEOUT + 2); end
    vec++; if (fault_code !== 2'b10) begin errs++; $display("FAIL timeout_code got=%b exp=10", fault_code); end
    pulse_clr();
  endtask

  task automatic test_timeout_edge();
    int c0;
    clear_logs();
    prog_q.push_back({4'h2, 12'($urandom)});
    prog_q.push_back(16'hF000);
    resp_delay = TIMEOUT + 1;
    c0 = cyc;
    run = 1'b1;
    repeat (30) tick();
    run = 1'b0;
    vec++; if (fault_seen) begin errs++; $display("FAIL edge_done_fault got=%b exp=0", fault_code); end
    vec++; if (dn_cyc.size() != 1 || dn_cyc[0] != c0 + 4 + TIMEOUT + 1) begin errs++; $display("FAIL edge_done_cycle got_n=%0d exp=1", dn_cyc.size()); end
    vec++; if (rd_cyc.size() != 2 || rd_cyc[1] != c0 + 4 + TIMEOUT + 1 + RECOVER + 1) begin errs++; $display("FAIL edge_next_rd got_n=%0d exp=2", rd_cyc.size()); end
    pulse_clr();
  endtask

  task automatic test_wrong_done();
    int c0;
    clear_logs();
    prog_q.push_back({4'h3, 12'($urandom)});
    resp_delay = 3;
    resp_mask = 8'h20;
    c0 = cyc;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (12) tick();
    vec++; if (flt_cyc != c0 + 8) begin errs++; $display("FAIL wrong_done_cycle got=%0d exp=8", flt_cyc - c0); end
    vec++; if (fault_code !== 2'b11) begin errs++; $display("FAIL wrong_done_code got=%b exp=11", fault_code); end
    pulse_clr();
    // several Done bits at once, including the right one
    clear_logs();
    prog_q.push_back({4'h3, 12'($urandom)});
    resp_delay = 2;
    resp_mask = 8'h28;
    c0 = cyc;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (12) tick();
    vec++; if (flt_cyc != c0 + 7 || fault_code !== 2'b11) begin errs++; $display("FAIL multi_done got_cyc=%0d code=%b exp=7 11", flt_cyc - c0, fault_code); end
    pulse_clr();
  endtask

  task automatic test_idle_done();
    int c0;
    clear_logs();
    pulse_clr();
    vec++; if ({fault, busy, halted} !== 3'b000 || rd_cyc.size() != 0) begin errs++; $display("FAIL idle_clr_noeffect got=%b rd=%0d exp=000 0", {fault, busy, halted}, rd_cyc.size()); end
    c0 = cyc;
    inj_done = 8'h02;
    repeat (4) tick();
    vec++; if (flt_cyc != c0 + 2) begin errs++; $display("FAIL idle_done_cycle got=%0d exp=2", flt_cyc - c0); end
    vec++; if (fault_code !== 2'b11 || busy !== 1'b0) begin errs++; $display("FAIL idle_done_code got=%b busy=%b exp=11 0", fault_code, busy); end
    pulse_clr();
  endtask

  task automatic test_halt();
    int c0;
    clear_logs();
    prog_q.push_back(16'hF123);
    c0 = cyc;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (6) tick();
    vec++; if ({halted, busy, fault} !== 3'b100) begin errs++; $display("FAIL halt_flags got=%b exp=100", {halted, busy, fault}); end
    vec++; if (st_cyc.size() != 0) begin errs++; $display("FAIL halt_start got=%0d exp=0", st_cyc.size()); end
    inj_done = 8'h01;
    repeat (2) tick();
    vec++; if (fault !== 1'b0) begin errs++; $display("FAIL halt_done_ignored got=%b exp=0", fault); end
    pulse_clr();
    vec++; if (halted !== 1'b0) begin errs++; $display("FAIL halt_clear got=%b exp=0", halted); end
  endtask

  task automatic test_run_drop();
    int c0, first_bz;
    clear_logs();
    prog_q.push_back({4'h1, 12'($urandom)});
    resp_delay = 4;
    c0 = cyc;
    run = 1'b1;
    repeat (6) tick();
    run = 1'b0;
    repeat (19) tick();
    first_bz = -1;
    foreach (bz_cyc[i]) if (first_bz < 0 && bz_cyc[i] > c0) first_bz = bz_cyc[i];
    vec++; if (fault_seen) begin errs++; $display("FAIL rundrop_fault got=%b exp=00", fault_code); end
    vec++; if (rd_cyc.size() != 1) begin errs++; $display("FAIL rundrop_rd_count got=%0d exp=1", rd_cyc.size()); end
    vec++; if (first_bz != c0 + 4 + 4 + RECOVER + 1) begin errs++; $display("FAIL rundrop_idle_cycle got=%0d exp=%0d", first_bz - c0, 4 + 4 + RECOVER + 1); end
  endtask

  task automatic test_async_reset();
    int c0;
    clear_logs();
    prog_q.push_back({4'h2, 12'($urandom)});
    resp_delay = 0;
    run = 1'b1;
    repeat (8) tick();
    #2 reset = 1'b0;
    #1;
    vec++; if ({start, imem_rd, busy, fault, halted} !== 12'h000) begin errs++; $display("FAIL areset_outputs got=%h exp=000", {start, imem_rd, busy, fault, halted}); end
    vec++; if (ir !== 16'h0000 || fault_code !== 2'b00) begin errs++; $display("FAIL areset_ir got=%h code=%b exp=0000 00", ir, fault_code); end
    clear_logs();
    repeat (3) tick();
    vec++; if (st_cyc.size() != 0 || rd_cyc.size() != 0) begin errs++; $display("FAIL areset_quiet got_st=%0d rd=%0d exp=0 0", st_cyc.size(), rd_cyc.size()); end
    prog_q.push_back({4'h0, 12'($urandom)});
    prog_q.push_back(16'hF000);
    resp_delay = 2;
    c0 = cyc;
    reset = 1'b1;
    repeat (14) tick();
    run = 1'b0;
    vec++; if (rd_cyc.size() < 1 || rd_cyc[0] != c0 + 1) begin errs++; $display("FAIL areset_refetch got_n=%0d exp first rd at +1", rd_cyc.size()); end
    vec++; if (st_cyc.size() != 1 || st_cyc[0] != c0 + 4 || st_val[0] !== 8'h01) begin errs++; $display("FAIL areset_restart got_n=%0d exp 01 at +4", st_cyc.size()); end
    pulse_clr();
  endtask

  // Random instruction streams: legal opcodes with random Done delays,
  // ending in HALT or, sometimes, a responder that never answers.
  task automatic test_random(input int rounds);
    int n, f, c0, d, end_c;
    bit last_to;
    logic [3:0] op;
    logic [15:0] w;
    for (int r = 0; r < rounds; r++) begin
      clear_logs();
      n = $urandom_range(3, 6);
      last_to = ($urandom_range(0, 3) == 0);
      c0 = cyc;
      f = c0 + 1;
      end_c = 0;
      for (int i = 0; i < n; i++) begin
        op = 4'($urandom_range(0, 7));
        w = {op, 12'($urandom)};
        d = (last_to && i == n - 1) ? 0 : $urandom_range(1, TIMEOUT + 1);
        prog_q.push_back(w);
        dly_q.push_back(d);
        exp_rd_q.push_back(f);
        exp_st_q.push_back(f + 3);
        exp_val_q.push_back(8'h01 << op);
        exp_ir_q.push_back(w);
        if (d == 0) end_c = f + 3 + TIMEOUT + 2;
        else f = f + 3 + d + RECOVER + 1;
      end
      if (!last_to) begin
        prog_q.push_back(16'hF000 | 16'($urandom_range(0, 4095)));
        exp_rd_q.push_back(f);
        end_c = f + 3;
      end
      run = 1'b1;
      repeat (end_c - c0 + 2) tick();
      run = 1'b0;
      vec++;
      if (rd_cyc.size() != exp_rd_q.size() || st_cyc.size() != exp_st_q.size()) begin
        errs++;
        $display("FAIL rand_counts got_rd=%0d st=%0d exp_rd=%0d st=%0d", rd_cyc.size(), st_cyc.size(), exp_rd_q.size(), exp_st_q.size());
      end else begin
        foreach (exp_rd_q[i]) begin
          vec++; if (rd_cyc[i] != exp_rd_q[i]) begin errs++; $display("FAIL rand_rd[%0d] got=%0d exp=%0d", i, rd_cyc[i] - c0, exp_rd_q[i] - c0); end
        end
        foreach (exp_st_q[i]) begin
          vec++; if (st_cyc[i] != exp_st_q[i]) begin errs++; $display("FAIL rand_st[%0d] got=%0d exp=%0d", i, st_cyc[i] - c0, exp_st_q[i] - c0); end
          vec++; if (st_val[i] !== exp_val_q[i]) begin errs++; $display("FAIL rand_val[%0d] got=%h exp=%h", i, st_val[i], exp_val_q[i]); end
          vec++; if (st_ir[i] !== exp_ir_q[i]) begin errs++; $display("FAIL rand_ir[%0d] got=%h exp=%h", i, st_ir[i], exp_ir_q[i]); end
        end
      end
      if (last_to) begin
        vec++; if (flt_cyc != end_c || fault_code !== 2'b10) begin errs++; $display("FAIL rand_timeout got_cyc=%0d code=%b exp=%0d 10", flt_cyc - c0, fault_code, end_c - c0); end
      end else begin
        vec++; if (halted !== 1'b1 || fault_seen) begin errs++; $display("FAIL rand_halt got_h=%b f=%b exp=1 0", halted, fault); end
      end
      pulse_clr();
    end
  endtask

  initial begin
    reset = 1'b0;
    run = 1'b0;
    fault_clr = 1'b0;
    imem_data = 16'h0000;
    done = 8'h00;
    inj_done = 8'h00;
    mem_pend = 1'b0;
    mem_word = 16'h0000;
    resp_delay = 0;
    resp_mask = 8'h00;
    rb_mask = 8'h00;
    cd = 0;
    fault_seen = 1'b0;
    flt_cyc = -1;
    test_reset();
    test_movi();
    test_illegal();
    test_timeout();
    test_timeout_edge();
    test_wrong_done();
    test_idle_done();
    test_halt();
    test_run_drop();
    test_async_reset();
    test_random(6);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
